// File: rtl/csr_unit_if.sv
// csr_unit_if: pipeline-facing CSR access, trap/MRET and interrupt signals of csr_unit.
interface csr_unit_if;
    logic        csr_en;
    logic [2:0]  csr_func;
    logic [11:0] csr_addr;
    logic [31:0] csr_src;
    logic        csr_src_zero;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret;
    logic        instr_retire;
    logic        ext_irq;
    logic        irq_pending;
    logic        trap_redirect;
    logic [31:0] trap_target;
    logic [1:0]  priv_mode;
    modport master (
        output csr_en, csr_func, csr_addr, csr_src, csr_src_zero, trap_valid, trap_cause,
               trap_pc, trap_tval, mret, instr_retire, ext_irq,
        input  csr_rdata, csr_illegal, irq_pending, trap_redirect, trap_target, priv_mode
    );
    modport slave (
        input  csr_en, csr_func, csr_addr, csr_src, csr_src_zero, trap_valid, trap_cause,
               trap_pc, trap_tval, mret, instr_retire, ext_irq,
        output csr_rdata, csr_illegal, irq_pending, trap_redirect, trap_target, priv_mode
    );
endinterface

// File: rtl/csr_unit.sv
// csr_unit: M-mode CSR file with trap/MRET sequencing and privilege tracking.
// Define CSR_COUNTERS_EN to add the mcycle/minstret counters and their user shadows.
module csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input logic       clk,
    input logic       reset,
    csr_unit_if.slave bus
);
    logic [1:0]  priv_q, priv_d, mpp_q, mpp_d;
    logic        mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d, meip_q;
    logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mscratch_q, mscratch_d;
    logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
    logic [31:0] old, wdata;
    logic [11:0] a;
    logic        hit, wr_try, illegal, wr, mret_ok;
`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
`else
    logic        unused_retire;
    assign unused_retire = bus.instr_retire;
`endif
    assign a = bus.csr_addr;
    always_comb begin
        hit = 1'b1;
        case (a)
            12'h300: old = {19'd0, mpp_q, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
            12'h301: old = 32'h4000_1100;
            12'h304: old = {20'd0, meie_q, 11'd0};
            12'h305: old = mtvec_q;
            12'h340: old = mscratch_q;
            12'h341: old = mepc_q;
            12'h342: old = mcause_q;
            12'h343: old = mtval_q;
            12'h344: old = {20'd0, meip_q, 11'd0};
            12'hF14: old = HART_ID;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: old = mcycle_q[31:0];
            12'hB80, 12'hC80: old = mcycle_q[63:32];
            12'hB02, 12'hC02: old = minstret_q[31:0];
            12'hB82, 12'hC82: old = minstret_q[63:32];
`endif
            default: begin
                old = 32'd0;
                hit = 1'b0;
            end
        endcase
    end
    // RS/RC with a zero source are pure reads and must not trip the read-only check
    assign wr_try  = bus.csr_func[1:0] == 2'b01 || !bus.csr_src_zero;
    assign illegal = bus.csr_en && (!hit || a[9:8] > priv_q || (wr_try && &a[11:10])
                     || bus.csr_func[1:0] == 2'b00);
    assign wdata   = bus.csr_func[1:0] == 2'b01 ? bus.csr_src
                   : bus.csr_func[1:0] == 2'b10 ? old | bus.csr_src : old & ~bus.csr_src;
    assign wr      = bus.csr_en && wr_try && !illegal && !bus.trap_valid && !bus.mret;
    assign mret_ok = bus.mret && !bus.trap_valid && priv_q == 2'b11;
    always_comb begin
        priv_d     = priv_q;
        mpp_d      = mpp_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        meie_d     = wr && a == 12'h304 ? wdata[11] : meie_q;
        mtvec_d    = wr && a == 12'h305 ? wdata & ~32'd3 : mtvec_q;
        mscratch_d = wr && a == 12'h340 ? wdata : mscratch_q;
        mepc_d     = wr && a == 12'h341 ? wdata & ~32'd3 : mepc_q;
        mcause_d   = wr && a == 12'h342 ? wdata : mcause_q;
        mtval_d    = wr && a == 12'h343 ? wdata : mtval_q;
        if (bus.trap_valid) begin
            mepc_d   = bus.trap_pc & ~32'd3;
            mcause_d = bus.trap_cause;
            mtval_d  = bus.trap_tval;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            mpp_d    = priv_q;
            priv_d   = 2'b11;
        end else if (mret_ok) begin
            priv_d = mpp_q;
            mie_d  = mpie_q;
            mpie_d = 1'b1;
            mpp_d  = 2'b00;
        end else if (wr && a == 12'h300) begin
            mie_d  = wdata[3];
            mpie_d = wdata[7];
            mpp_d  = {2{&wdata[12:11]}};
        end
    end
`ifdef CSR_COUNTERS_EN
    // a write to either half replaces it and swallows that cycle's increment
    assign mcycle_d   = wr && a == 12'hB00 ? {mcycle_q[63:32], wdata}
                      : wr && a == 12'hB80 ? {wdata, mcycle_q[31:0]} : mcycle_q + 64'd1;
    assign minstret_d = wr && a == 12'hB02 ? {minstret_q[63:32], wdata}
                      : wr && a == 12'hB82 ? {wdata, minstret_q[31:0]}
                      : minstret_q + {63'd0, bus.instr_retire};
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            priv_q     <= 2'b11;
            mpp_q      <= 2'b00;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            meie_q     <= 1'b0;
            meip_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET & ~32'd3;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
`ifdef CSR_COUNTERS_EN
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
`endif
        end else begin
            priv_q     <= priv_d;
            mpp_q      <= mpp_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            meie_q     <= meie_d;
            meip_q     <= bus.ext_irq;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
`ifdef CSR_COUNTERS_EN
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
`endif
        end
    end
    assign bus.csr_rdata     = reset ? 32'd0 : old;
    assign bus.csr_illegal   = !reset && illegal;
    assign bus.irq_pending   = !reset && mie_q && meie_q && meip_q;
    assign bus.trap_redirect = !reset && (bus.trap_valid || bus.mret);
    assign bus.trap_target   = reset ? 32'd0 : bus.trap_valid ? mtvec_q : bus.mret ? mepc_q : 32'd0;
    assign bus.priv_mode     = priv_q;
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed test-plan steps plus random traffic checked against an architectural CSR model.
module tb_csr_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    csr_unit_if bus();
    csr_unit dut (.clk(clk), .reset(reset), .bus(bus));

    localparam logic [11:0] POOL [11] = '{12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                          12'h343, 12'h344, 12'hF14, 12'h7C0, 12'h123};
    int checks = 0;
    int passed = 0;
    logic [31:0] regs [logic [11:0]];
    logic [1:0]  m_priv;
    logic        m_meip, irq_lvl;
    logic [63:0] m_cyc, m_ins;
    logic [31:0] obs_rdata, obs_tgt;
    logic        obs_ill, obs_redir, obs_irq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic m_reset();
        regs.delete();
        regs[12'h300] = 0; regs[12'h304] = 0; regs[12'h305] = 32'h100;
        regs[12'h340] = 0; regs[12'h341] = 0; regs[12'h342] = 0; regs[12'h343] = 0;
        m_priv = 2'b11; m_meip = 0; m_cyc = 0; m_ins = 0;
    endtask

    function automatic logic [31:0] wmask(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1888;
            12'h304: return 32'h0000_0800;
            12'h305, 12'h341: return 32'hFFFF_FFFC;
            12'h340, 12'h342, 12'h343: return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit impl(input logic [11:0] a);
`ifdef CSR_COUNTERS_EN
        if (a inside {12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82}) return 1;
`endif
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                         12'h344, 12'hF14};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h301: return 32'h4000_1100;
            12'h344: return {20'd0, m_meip, 11'd0};
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            default: return regs.exists(a) ? regs[a] : 32'h0;
        endcase
    endfunction

    // drive at negedge, check combinational outputs 1ns later, advance model at posedge
    task automatic step(input logic en, input logic [2:0] f, input logic [11:0] a, input logic [31:0] s,
                        input logic tv, input logic [31:0] tc, input logic [31:0] tp, input logic [31:0] tt,
                        input logic mr, input logic ret, input logic irq);
        logic [31:0] old, nv, st;
        logic ill, wt, wr;
        bus.csr_en = en; bus.csr_func = f; bus.csr_addr = a; bus.csr_src = s; bus.csr_src_zero = (s == 0);
        bus.trap_valid = tv; bus.trap_cause = tc; bus.trap_pc = tp; bus.trap_tval = tt;
        bus.mret = mr; bus.instr_retire = ret; bus.ext_irq = irq;
        #1;
        old = m_read(a);
        wt = f[1:0] == 2'b01 || s != 0;
        ill = en && (!impl(a) || a[9:8] > m_priv || (wt && a[11:10] == 2'b11) || f[1:0] == 2'b00);
        obs_rdata = bus.csr_rdata; obs_ill = bus.csr_illegal; obs_redir = bus.trap_redirect;
        obs_tgt = bus.trap_target; obs_irq = bus.irq_pending;
        st = regs[12'h300];
        if (en) check("rdata", obs_rdata, old);
        check("illegal", obs_ill, ill);
        check("redirect", obs_redir, tv | mr);
        check("target", obs_tgt, tv ? regs[12'h305] : mr ? regs[12'h341] : 32'h0);
        check("irq_pending", obs_irq, st[3] & regs[12'h304][11] & m_meip);
        check("priv", bus.priv_mode, m_priv);
        @(posedge clk);
        nv = f[1:0] == 2'b01 ? s : f[1:0] == 2'b10 ? (old | s) : (old & ~s);
        wr = en && !ill && wt && !tv && !mr;
        if (tv) begin
            regs[12'h341] = tp & ~32'd3; regs[12'h342] = tc; regs[12'h343] = tt;
            regs[12'h300] = (32'(m_priv) << 11) | (32'(st[3]) << 7);
            m_priv = 2'b11;
        end else if (mr && m_priv == 2'b11) begin
            m_priv = st[12:11];
            regs[12'h300] = 32'h80 | (32'(st[7]) << 3);
        end else if (wr && regs.exists(a)) begin
            regs[a] = (regs[a] & ~wmask(a)) | (nv & wmask(a));
        end
`ifdef CSR_COUNTERS_EN
        if (wr && a == 12'hB00) m_cyc[31:0] = nv;
        else if (wr && a == 12'hB80) m_cyc[63:32] = nv;
        else m_cyc = m_cyc + 1;
        if (wr && a == 12'hB02) m_ins[31:0] = nv;
        else if (wr && a == 12'hB82) m_ins[63:32] = nv;
        else m_ins = m_ins + 64'(ret);
`endif
        m_meip = irq;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 3'b000, 12'h000, 0, 0, 0, 0, 0, 0, 0, irq_lvl);
    endtask

    task automatic op(input logic [2:0] f, input logic [11:0] a, input logic [31:0] s);
        step(1, f, a, s, 0, 0, 0, 0, 0, 0, irq_lvl);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        op(3'b010, a, 0);
        check(tag, obs_rdata, exp);
    endtask

    initial begin
        logic en, tv, mr;
        logic [2:0] f;
        logic [11:0] a;
        logic [31:0] s;
        bus.csr_en = 1; bus.csr_func = 3'b001; bus.csr_addr = 12'h340; bus.csr_src = 32'h1234;
        bus.csr_src_zero = 0; bus.trap_valid = 1; bus.trap_cause = 1; bus.trap_pc = 32'h44;
        bus.trap_tval = 0; bus.mret = 1; bus.instr_retire = 1; bus.ext_irq = 1;
        irq_lvl = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", bus.csr_rdata, 0);
        check("rst_illegal", bus.csr_illegal, 0);
        check("rst_irq", bus.irq_pending, 0);
        check("rst_redirect", bus.trap_redirect, 0);
        check("rst_target", bus.trap_target, 0);
        check("rst_priv", bus.priv_mode, 2'b11);
        bus.csr_en = 0; bus.trap_valid = 0; bus.mret = 0; bus.instr_retire = 0; bus.ext_irq = 0;
        reset = 0;
        m_reset();

        rd(12'h300, 32'h0, "mstatus_rst");
        rd(12'h305, 32'h100, "mtvec_rst");
        rd(12'h301, 32'h4000_1100, "misa");
        rd(12'hF14, 32'h0, "mhartid");

        op(3'b001, 12'h340, 32'hDEAD_BEEF);
        op(3'b010, 12'h340, 32'h0000_00F0);
        check("rs_old", obs_rdata, 32'hDEAD_BEEF);
        rd(12'h340, 32'hDEAD_BEFF, "mscratch_rs");
        op(3'b011, 12'h340, 0);
        rd(12'h340, 32'hDEAD_BEFF, "mscratch_rc0");

        op(3'b110, 12'h300, 32'h8);
        op(3'b010, 12'h304, 32'h800);
        irq_lvl = 1;
        idle();
        check("irq_lag", obs_irq, 0);
        step(0, 3'b000, 12'h000, 0, 1, 32'h8000_000B, 32'h42, 0, 0, 0, irq_lvl);
        check("irq_now", obs_irq, 1);
        check("trap_redirect", obs_redir, 1);
        check("trap_target", obs_tgt, 32'h100);
        rd(12'h341, 32'h40, "mepc_trap");
        rd(12'h300, 32'h1880, "mstatus_trap");
        rd(12'h342, 32'h8000_000B, "mcause_trap");

        step(0, 3'b000, 12'h000, 0, 0, 0, 0, 0, 1, 0, irq_lvl);
        check("mret_target", obs_tgt, 32'h40);
        step(0, 3'b000, 12'h000, 0, 0, 0, 0, 0, 1, 0, irq_lvl);
        check("priv_user", bus.priv_mode, 2'b00);
        op(3'b001, 12'h305, 32'h200);
        check("u_mtvec_ill", obs_ill, 1);
        step(0, 3'b000, 12'h000, 0, 1, 32'h2, 32'h80, 0, 0, 0, irq_lvl);
        rd(12'h305, 32'h100, "mtvec_kept");
        op(3'b001, 12'hF14, 32'h1);
        check("hartid_wr_ill", obs_ill, 1);
        op(3'b000, 12'h340, 32'h1);
        check("func0_ill", obs_ill, 1);
        op(3'b100, 12'h340, 32'h1);
        check("func4_ill", obs_ill, 1);

        step(1, 3'b001, 12'h340, 32'h1234, 1, 32'h5, 32'h100, 32'h77, 0, 0, irq_lvl);
        rd(12'h340, 32'hDEAD_BEFF, "trap_vs_wr");
        rd(12'h343, 32'h77, "mtval_trap");
        step(0, 3'b000, 12'h000, 0, 1, 32'h3, 32'h8, 0, 1, 0, irq_lvl);
        check("trap_vs_mret", obs_tgt, 32'h100);

`ifdef CSR_COUNTERS_EN
        op(3'b001, 12'hB00, 32'hFFFF_FFFF);
        idle();
        idle();
        rd(12'hB00, 32'h1, "mcycle");
        rd(12'hB80, 32'h1, "mcycleh");
`else
        op(3'b010, 12'hB00, 0);
        check("no_counters", obs_ill, 1);
`endif

        irq_lvl = 0;
        for (int i = 0; i < 300; i++) begin
            en = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            a = POOL[$urandom_range(0, 10)];
            s = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            tv = $urandom_range(0, 9) == 0;
            mr = !en && $urandom_range(0, 5) == 0;
            step(en, f, a, s, tv, $urandom, $urandom, $urandom, mr, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        bus.csr_en = 1; bus.csr_func = 3'b001; bus.csr_addr = 12'h340; bus.csr_src = 32'h5555;
        bus.csr_src_zero = 0; bus.trap_valid = 1; bus.mret = 0;
        #2 reset = 1;
        #1;
        check("midrst_rdata", bus.csr_rdata, 0);
        check("midrst_redirect", bus.trap_redirect, 0);
        check("midrst_target", bus.trap_target, 0);
        check("midrst_priv", bus.priv_mode, 2'b11);
        @(posedge clk);
        @(negedge clk);
        bus.csr_en = 0; bus.trap_valid = 0; bus.ext_irq = 0; bus.instr_retire = 0;
        reset = 0;
        m_reset();
        rd(12'h340, 32'h0, "mscratch_after_rst");
        rd(12'h305, 32'h100, "mtvec_after_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode control and status register file with trap/return sequencing for the RV32IM pipeline. Sits beside the execute stage: executes CSRRW/S/C(I) in EX, records trap state when the pipeline's trap logic fires, and produces the redirect target and flush request (`flush_trap`) that the fetch stage consumes. It owns the current privilege level and the external-interrupt pending logic.

## Interface
- `MTVEC_RESET`, 32'h0000_0100, reset value of mtvec (direct mode).
- `HART_ID`, 0, value returned by mhartid.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `csr_en`  in  1  valid CSR instruction in EX this cycle.
- `csr_func`  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- `csr_addr`  in  12  CSR address.
- `csr_src`  in  32  rs1 value, or zero-extended zimm for I-variants (muxed by execute).
- `csr_src_zero`  in  1  rs1 field / zimm is zero; suppresses write for RS/RC forms.
- `csr_rdata`  out  32  old CSR value for rd (combinational).
- `csr_illegal`  out  1  access violation (combinational); feeds `trap_csr_access_violation`.
- `trap_valid`  in  1  take trap this cycle.
- `trap_cause`  in  32  mcause value (bit31 = interrupt).
- `trap_pc`  in  32  PC of trapping instruction.
- `trap_tval`  in  32  faulting address/instruction, else 0.
- `mret`  in  1  MRET in EX this cycle.
- `instr_retire`  in  1  one instruction retired this cycle.
- `ext_irq`  in  1  level external interrupt (gpio0|gpio1).
- `irq_pending`  out  1  mstatus.MIE & mie.MEIE & mip.MEIP.
- `trap_redirect`  out  1  flush + PC redirect request (combinational).
- `trap_target`  out  32  redirect PC.
- `priv_mode`  out  2  current privilege; 11 = M, 00 = U.

## Operation
- Implemented CSRs:
  - mstatus 0x300: MIE[3], MPIE[7], MPP[12:11]; other bits read 0.
  - misa 0x301: RO 32'h4000_1100.
  - mie 0x304: MEIE[11] only.
  - mtvec 0x305: [31:2] writable, [1:0] read 0.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: [1:0] read 0.
  - mcause 0x342, mtval 0x343: full 32 bits.
  - mip 0x344: MEIP[11] = registered `ext_irq`, RO.
  - mhartid 0xF14: RO `HART_ID`.
- Write value:
  - RW: src.
  - RS: old|src.
  - RC: old&~src.
  - RS/RC with `csr_src_zero` perform no write (read only).
- `csr_illegal` when `csr_en` and any of:
  - unimplemented address;
  - `csr_addr[9:8]` > `priv_mode`;
  - write attempted to `csr_addr[11:10]`==11;
  - `csr_func` 000 or 100.
- An illegal access never updates state.
- Trap (`trap_valid`):
  - mepc <= `trap_pc` & ~3; mcause <= `trap_cause`; mtval <= `trap_tval`.
  - MPIE <= MIE; MIE <= 0; MPP <= `priv_mode`; `priv_mode` <= 11.
- MRET:
  - `priv_mode` <= MPP; MIE <= MPIE; MPIE <= 1; MPP <= 00.
  - MRET while `priv_mode` != 11 is not executed; the pipeline reports it as illegal.
- `trap_redirect` = `trap_valid` | `mret`.
- `trap_target`:
  - `trap_valid`: {mtvec[31:2], 2'b00}.
  - else `mret`: mepc.
  - else 0.
- Priority in the same cycle:
  - `trap_valid` > `mret` > CSR write.
  - A CSR write or MRET coincident with `trap_valid` is discarded. The trap wins; the faulting instruction has no side effects.

## Timing
- Reset values:
  - `priv_mode` = 11.
  - mstatus = 0, mie = 0, mip = 0, mscratch = 0, mepc = 0, mcause = 0, mtval = 0.
  - mtvec = `MTVEC_RESET`.
  - Counters = 0.
- Output values while in reset:
  - `csr_rdata` = 0, `csr_illegal` = 0, `irq_pending` = 0.
  - `trap_redirect` = 0, `trap_target` = 0.
- Reset mid-operation discards any in-progress write or trap.
- `csr_rdata`, `csr_illegal`, `trap_redirect` and `trap_target` are combinational from current state and inputs. Zero cycles of latency.
- Writes and trap/MRET updates commit on the next rising edge. A read in the following cycle returns the new value; there is no internal bypass.
- mip.MEIP samples `ext_irq` every cycle, so `irq_pending` lags `ext_irq` by 1 cycle.
- Inputs are single-cycle qualified. The pipeline holds `csr_en`/`mret` low while stalled.

## Configuration
- `CSR_COUNTERS_EN` defined: adds 64-bit counters mcycle and minstret.
  - mcycle: 0xB00 low / 0xB80 high, increments every cycle out of reset.
  - minstret: 0xB02 / 0xB82, increments on `instr_retire`.
  - Read-only user shadows cycle 0xC00/0xC80 and instret 0xC02/0xC82. These pass the privilege check from U mode.
  - A CSR write to a counter half replaces that half and suppresses that cycle's increment.
  - Low-half carry into the high half occurs on the increment edge.
- Not defined: counter addresses are unimplemented and raise `csr_illegal`.

## Test plan
- Reset, then read 0x300/0x305/0x301/0xF14 → 0, 32'h100, 32'h4000_1100, `HART_ID`.
- CSRRW 0x340 src=32'hDEAD_BEEF, next cycle CSRRS src=32'h0000_00F0 → returns DEADBEEF; then mscratch = DEADBEFF. CSRRC with `csr_src_zero` → no change.
- mstatus.MIE=1, mie.MEIE=1, raise `ext_irq` → `irq_pending` = 1 one cycle later. Then trap_valid with cause 32'h8000_000B, pc 32'h0000_0042:
  - same cycle: redirect=1, target=32'h100;
  - next cycle: mepc=0x40, MIE=0, MPIE=1, MPP=11.
- From U mode (after MRET with MPP=00), access 0x305 → `csr_illegal` = 1, mtvec unchanged. Write to 0xF14 in M mode → illegal.
- Simultaneous `trap_valid` + `csr_en` write to mscratch → mscratch unchanged, trap recorded. Simultaneous `trap_valid` + `mret` → target = mtvec.
- With `CSR_COUNTERS_EN`: write mcycle = 32'hFFFF_FFFF, run 2 cycles → mcycleh = 1, mcycle = 1. Without it, read 0xB00 → `csr_illegal` = 1.
